// File: rtl/ifu_pkg.sv
// Shared fetch-unit definitions: bus widths, the AXI OKAY response code,
// and the IFU state encoding used by the RTL and the bench.
`ifndef IFU_DEFINES
`define IFU_DEFINES
`define INST_ADDR_BUS 32
`define INST_DATA_BUS 32
`define AXI_RESP_OKAY 2'b00
`endif

package ifu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10,
    HOLD = 2'b11
  } ifu_state_e;

  // Instructions are word-aligned; any set low bit is a fetch fault.
  function automatic logic pc_aligned(input logic [1:0] pc_lsb);
    return (pc_lsb == 2'b00);
  endfunction

endpackage

// File: rtl/ifu_axi.sv
// Instruction fetch unit: takes one PC at a time, reads it over AXI-lite and
// holds the instruction (or a fault) until decode takes it.
module ifu_axi
  import ifu_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      pc_valid,
  output logic                      pc_ready,
  input  logic [`INST_ADDR_BUS-1:0] fetch_pc,
  output logic [`INST_ADDR_BUS-1:0] araddr,
  output logic                      arvalid,
  input  logic                      arready,
  input  logic [`INST_DATA_BUS-1:0] rdata,
  input  logic [1:0]                rresp,
  input  logic                      rvalid,
  output logic                      rready,
  output logic [`INST_DATA_BUS-1:0] inst,
  output logic [`INST_ADDR_BUS-1:0] inst_pc,
  output logic                      inst_err,
  output logic                      inst_valid,
  input  logic                      inst_ready
);

  ifu_state_e                state;
  logic [`INST_ADDR_BUS-1:0] pc_reg;
  logic                      accept;

  // HOLD can take the next PC in the same cycle decode drains it, so there is no bubble.
  assign pc_ready = rst_n & ((state == IDLE) | ((state == HOLD) & inst_ready));
  assign accept   = pc_valid & pc_ready;
  assign araddr   = pc_reg;
  assign inst_pc  = pc_reg;

  // Fetch sequencer with registered bus and decode-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc_reg     <= {`INST_ADDR_BUS{1'b0}};
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      inst       <= {`INST_DATA_BUS{1'b0}};
      inst_err   <= 1'b0;
      inst_valid <= 1'b0;
    end else if (accept) begin
      pc_reg <= fetch_pc;
      if (pc_aligned(fetch_pc[1:0])) begin
        state      <= ADDR;
        arvalid    <= 1'b1;
        inst_valid <= 1'b0;
      end else begin
        state      <= HOLD;
        inst       <= {`INST_DATA_BUS{1'b0}};
        inst_err   <= 1'b1;
        inst_valid <= 1'b1;
      end
    end else begin
      case (state)
        IDLE: begin
          state <= IDLE;
        end
        ADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= DATA;
          end
        end
        DATA: begin
          if (rvalid) begin
            rready     <= 1'b0;
            inst       <= rdata;
            inst_err   <= (rresp != `AXI_RESP_OKAY);
            inst_valid <= 1'b1;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (inst_ready) begin
            inst_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          arvalid    <= 1'b0;
          rready     <= 1'b0;
          inst_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_axi.sv
// Scoreboard bench for ifu_axi: directed fetches against a scripted AXI-lite
// slave; a negedge monitor pops expected instructions on each decode handshake.
module tb_ifu_axi;
  import ifu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_valid;
  logic        pc_ready;
  logic [31:0] fetch_pc;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_err;
  logic        inst_valid;
  logic        inst_ready;

  ifu_axi dut (
    .clk(clk), .rst_n(rst_n), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .fetch_pc(fetch_pc), .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .inst(inst), .inst_pc(inst_pc), .inst_err(inst_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          ar_hs = 0;
  logic [64:0] exp_q[$];
  logic [64:0] exp_e;

  logic [31:0] s_data = 32'h0;
  logic [1:0]  s_resp = 2'b00;
  int          ar_wait_cfg = 0;
  bit          r_block = 1'b0;
  bit          stray = 1'b0;
  ifu_state_e  slave_phase;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scripted slave: arready after ar_wait_cfg cycles, zero-wait read data.
  initial begin
    int cnt;
    cnt = 0;
    arready = 1'b0;
    rvalid = 1'b0;
    rdata = 32'h0;
    rresp = 2'b00;
    forever begin
      @(posedge clk);
      #2;
      slave_phase = arvalid ? ADDR : (rready ? DATA : IDLE);
      if (!arvalid) begin
        cnt = ar_wait_cfg;
        arready = 1'b0;
      end else if (cnt > 0) begin
        cnt--;
        arready = 1'b0;
      end else begin
        arready = 1'b1;
      end
      rvalid = ((slave_phase == DATA) && !r_block) || stray;
      rdata  = stray ? 32'hBAD0_BAD0 : s_data;
      rresp  = stray ? 2'b00 : s_resp;
    end
  end

  logic        prev_arv = 1'b0;
  logic        prev_arr = 1'b0;
  logic [31:0] prev_ara = 32'h0;
  logic        prev_iv = 1'b0;
  logic        prev_ir = 1'b0;
  logic [64:0] prev_out = 65'h0;

  // Monitor: handshake counting, stability while stalled, scoreboard pops.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (arvalid && arready) ar_hs <= ar_hs + 1;
      if (prev_arv && !prev_arr)
        chk("ar_stable", 96'({arvalid, araddr}), 96'({1'b1, prev_ara}));
      if (prev_iv && !prev_ir)
        chk("hold_stable", 96'({inst_valid, inst, inst_pc, inst_err}), 96'({1'b1, prev_out}));
      if (inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_inst: actual inst=%0h pc=%0h err=%0b required none", inst, inst_pc, inst_err);
        end else begin
          exp_e = exp_q.pop_front();
          chk("inst_out", 96'({inst, inst_pc, inst_err}), 96'(exp_e));
        end
      end
      prev_arv <= arvalid;
      prev_arr <= arready;
      prev_ara <= araddr;
      prev_iv  <= inst_valid;
      prev_ir  <= inst_ready;
      prev_out <= {inst, inst_pc, inst_err};
    end else begin
      prev_arv <= 1'b0;
      prev_iv  <= 1'b0;
    end
  end

  task automatic issue(input logic [31:0] pc);
    fetch_pc = pc;
    pc_valid = 1'b1;
    @(negedge clk);
    chk("pc_ready_at_accept", 96'(pc_ready), 96'(1));
    step();
    pc_valid = 1'b0;
  endtask

  task automatic wait_valid(input string nm, input int exp_lat, input logic exp_arv);
    bit found;
    int lat;
    found = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (!found) begin
        @(negedge clk);
        if (k == 1) chk({nm, "_first_arvalid"}, 96'(arvalid), 96'(exp_arv));
        if (inst_valid) begin
          found = 1'b1;
          lat = k;
        end else begin
          step();
        end
      end
    end
    chk({nm, "_latency"}, 96'(lat), 96'(exp_lat));
  endtask

  task automatic fetch(input string nm, input logic [31:0] pc, input logic [31:0] data,
                       input logic [1:0] resp, input int wt,
                       input logic [31:0] ei, input logic ee);
    int   hs0;
    logic al;
    al = (pc[1:0] == 2'b00);
    s_data = data;
    s_resp = resp;
    ar_wait_cfg = wt;
    step();
    hs0 = ar_hs;
    exp_q.push_back({ei, pc, ee});
    issue(pc);
    wait_valid(nm, al ? 3 + wt : 1, al);
    chk({nm, "_ar_count"}, 96'(ar_hs - hs0), 96'(al ? 1 : 0));
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;
    rst_n = 1'b0;
    pc_valid = 1'b0;
    fetch_pc = 32'h0;
    inst_ready = 1'b1;
    #3;
    chk("reset_ctrl", 96'({pc_ready, arvalid, rready, inst_valid, inst_err}), 96'(0));
    chk("reset_regs", 96'({araddr, inst, inst_pc}), 96'(0));
    step();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("pc_ready_release", 96'(pc_ready), 96'(1));

    fetch("zero_wait",  32'h8000_0000, 32'h0000_0413, 2'b00, 0, 32'h0000_0413, 1'b0);
    fetch("ar_wait4",   32'h8000_0004, 32'h0010_0093, 2'b00, 4, 32'h0010_0093, 1'b0);
    fetch("slverr",     32'h8000_0010, 32'hDEAD_BEEF, 2'b10, 0, 32'hDEAD_BEEF, 1'b1);
    fetch("decerr",     32'h8000_0014, 32'h1234_5678, 2'b11, 1, 32'h1234_5678, 1'b1);
    fetch("misaligned", 32'h8000_0002, 32'hFFFF_FFFF, 2'b00, 0, 32'h0000_0000, 1'b1);

    // Decode stalls five cycles, then drains while the next PC is accepted.
    s_data = 32'h00A0_0093;
    s_resp = 2'b00;
    ar_wait_cfg = 0;
    inst_ready = 1'b0;
    step();
    exp_q.push_back({32'h00A0_0093, 32'h8000_0018, 1'b0});
    issue(32'h8000_0018);
    wait_valid("stall_first", 3, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step();
      @(negedge clk);
      chk("stall_pc_ready", 96'(pc_ready), 96'(0));
    end
    s_data = 32'h00C0_0193;
    step();
    inst_ready = 1'b1;
    exp_q.push_back({32'h00C0_0193, 32'h8000_0008, 1'b0});
    issue(32'h8000_0008);
    wait_valid("b2b", 3, 1'b1);
    step();

    // Reset lands while the read is outstanding.
    r_block = 1'b1;
    s_data = 32'h0BAD_F00D;
    step();
    issue(32'h8000_0020);
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (!found) begin
        @(negedge clk);
        if (rready) found = 1'b1;
        else step();
      end
    end
    chk("reach_data", 96'(found), 96'(1));
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ctrl", 96'({pc_ready, arvalid, rready, inst_valid, inst_err}), 96'(0));
    chk("async_rst_regs", 96'({araddr, inst, inst_pc}), 96'(0));
    stray = 1'b1;
    r_block = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("pc_ready_after_rst", 96'(pc_ready), 96'(1));
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clk);
      chk("stray_rvalid_ignored", 96'({inst_valid, rready, arvalid}), 96'(0));
    end
    stray = 1'b0;
    step();
    fetch("post_reset", 32'h8000_0024, 32'h00B0_0113, 2'b00, 0, 32'h00B0_0113, 1'b0);

    step();
    chk("queue_empty", 96'(exp_q.size()), 96'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ifu_axi.md
IFU_AXI -- requirements
Module: ifu_axi

Interface
REQ-001 Parameters SHALL be none; all widths SHALL come from the shared defines (INST_ADDR_BUS = 32 bits, INST_DATA_BUS = 32 bits).
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 pc_valid  in  1  PC stage holds a valid fetch PC.
REQ-005 pc_ready  out  1  IFU accepts fetch_pc this cycle.
REQ-006 fetch_pc  in  32  PC to fetch.
REQ-007 araddr  out  32  AXI-lite read address.
REQ-008 arvalid  out  1  AXI-lite read-address valid.
REQ-009 arready  in  1  AXI-lite read-address ready.
REQ-010 rdata  in  32  AXI-lite read data.
REQ-011 rresp  in  2  AXI-lite read response.
REQ-012 rvalid  in  1  AXI-lite read-data valid.
REQ-013 rready  out  1  AXI-lite read-data ready.
REQ-014 inst  out  32  fetched instruction to decode.
REQ-015 inst_pc  out  32  PC of inst.
REQ-016 inst_err  out  1  fetch fault: misaligned PC or rresp != OKAY.
REQ-017 inst_valid  out  1  inst, inst_pc and inst_err are valid.
REQ-018 inst_ready  in  1  decode accepts inst.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, ADDR, DATA and HOLD.
REQ-020 pc_ready SHALL be 1 in IDLE, and in HOLD when inst_ready=1; it SHALL be 0 otherwise.
REQ-021 On a PC accept (pc_valid & pc_ready):
- fetch_pc SHALL be registered into the address/PC register.
- If fetch_pc[1:0]=0, the next state SHALL be ADDR.
- Otherwise the next state SHALL be HOLD, with inst=0 and inst_err=1, and no bus access.
REQ-022 ADDR: arvalid=1 and araddr=the registered PC; both SHALL stay stable until arready=1, then the FSM SHALL go to DATA.
REQ-023 DATA: rready=1; on rvalid the FSM SHALL capture inst=rdata, set inst_err=(rresp != 2'b00), and go to HOLD.
REQ-024 HOLD: inst_valid=1, and inst/inst_pc/inst_err SHALL be stable until inst_ready=1.
REQ-025 HOLD with inst_ready=1 and no new PC SHALL go to IDLE; with a simultaneous PC accept, it SHALL go straight to ADDR (or HOLD if misaligned) with no idle bubble.
REQ-026 At most one AR transaction SHALL be outstanding; arvalid SHALL never deassert before arready.
REQ-027 rvalid arriving outside DATA SHALL be ignored (rready=0).
REQ-028 Minimum latency: accept at cycle N, arvalid at N+1, arready at N+1 with rvalid at N+2 gives inst_valid at N+3.
REQ-029 Back-to-back throughput SHALL be one instruction per 3 cycles with a zero-wait slave.
REQ-030 Any rresp other than OKAY SHALL set inst_err=1, and rdata SHALL still be forwarded.

Reset
REQ-031 While rst_n=0: state=IDLE; pc_ready, arvalid, rready, inst_valid and inst_err SHALL be 0; araddr, inst and inst_pc SHALL be 0.
REQ-032 pc_ready SHALL be gated low while rst_n=0 and SHALL rise in the first cycle after release.
REQ-033 Reset asserted mid-transaction SHALL abort it immediately, and no partial inst SHALL be presented after release.

Structure
REQ-034 INST_ADDR_BUS, INST_DATA_BUS and AXI_RESP_OKAY SHALL live in the shared defines header.
REQ-035 The state enum SHALL live in a shared package, ifu_pkg, for reuse by the bench.
REQ-036 No sub-module is required; the FSM and output registers SHALL be a single module.

Verification
REQ-037 Zero-wait slave: fetch_pc=0x8000_0000, rdata=0x0000_0413, rresp=0 -> inst_valid at N+3, inst=0x0000_0413, inst_pc=0x8000_0000, inst_err=0.
REQ-038 arready held low 4 cycles -> araddr=0x8000_0004 and arvalid=1 stable all 4 cycles; exactly one AR handshake.
REQ-039 rresp=2'b10 (SLVERR) -> inst_err=1 and inst=rdata.
REQ-040 fetch_pc=0x8000_0002 -> arvalid stays 0, inst_valid next cycle, inst_err=1, inst=0.
REQ-041 inst_ready low 5 cycles then high with pc_valid=1 (fetch_pc=0x8000_0008) -> outputs stable while stalled; ADDR entered the cycle after the accept.
REQ-042 rst_n pulsed low in DATA -> all outputs 0 asynchronously; a later rvalid SHALL be ignored; a clean fetch SHALL follow.
